setuphold_viol_monitor: RTL and testbench

//  Consumes the notifier driven by the clock/data $setuphold checks of the capture stage.

---
 rtl/setuphold_viol_monitor.sv | 176 +++++++++++++++++
 tb/tb_setuphold_viol_monitor.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/setuphold_viol_monitor.sv
// setuphold_viol_monitor: turns $setuphold notifier toggles into synchronous,
// timestamped violation events. It queues them in a small FIFO and keeps a
// saturating count plus sticky error/overflow flags.
// Optional feature macro: VIOL_HOLD_LAST_EN. When defined, a mode=1 capture
// edge that coincides with a violation pulse keeps the last good q.
module setuphold_viol_monitor #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned TS_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             data,
    input  logic             ntfr,
    input  logic             clr,
    output logic             q,
    output logic             q_err,
    output logic [CNT_W-1:0] viol_cnt,
    output logic             ovf,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic             ev_mode,
    output logic [TS_W-1:0]  ev_ts
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned EW = TS_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } rpt_state_e;

    // notifier synchroniser, reference flop and arming
    logic             s1_q, s2_q, s3_q;
    logic [1:0]       arm_cnt_q, arm_cnt_d;
    logic             armed;
    logic             viol_p;

    // timestamp, capture, statistics
    logic [TS_W-1:0]  ts_q, ts_d;
    logic             q_q, q_d;
    logic             hold;
    logic             q_err_q, q_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    // event FIFO
    logic [EW-1:0]    mem_q [DEPTH];
    logic [EW-1:0]    head;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             full;
    logic             pop, push, drop;

    // report FSM
    rpt_state_e       state_q, state_d;

    // The synchroniser needs three edges after reset before s2/s3 reflect the
    // real notifier level, so arming is held off for that long. A notifier
    // already high at reset release is then absorbed without a false event.
    assign armed  = (arm_cnt_q == 2'd3);
    assign viol_p = armed & (s2_q ^ s3_q);

`ifdef VIOL_HOLD_LAST_EN
    assign hold = viol_p;
`else
    assign hold = 1'b0;
`endif

    assign full = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop  = (state_q == SHOW) & ev_ready;
    assign push = viol_p & (~full | pop);
    assign drop = viol_p & full & ~pop;

    // next-state for counters, flags, capture and FIFO pointers
    always_comb begin
        arm_cnt_d = arm_cnt_q;
        ts_d      = ts_q + TS_W'(1);
        q_d       = q_q;
        q_err_d   = q_err_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, pop};

        if (!armed) begin
            arm_cnt_d = arm_cnt_q + 2'd1;
        end

        if (mode && !hold) begin
            q_d = data;
        end

        if (clr) begin
            cnt_d   = viol_p ? CNT_W'(1) : '0;
            q_err_d = viol_p & mode;
            ovf_d   = drop;
        end else begin
            if (viol_p && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (viol_p && mode) begin
                q_err_d = 1'b1;
            end
            if (drop) begin
                ovf_d = 1'b1;
            end
        end
    end

    // report FSM next state: SHOW whenever the FIFO holds an entry next cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (wr_ptr_d != rd_ptr_d) state_d = SHOW;
            SHOW:    if (pop && (wr_ptr_d == rd_ptr_d)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            arm_cnt_q <= '0;
            ts_q      <= '0;
            q_q       <= 1'b0;
            q_err_q   <= 1'b0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            state_q   <= IDLE;
        end else begin
            s1_q      <= ntfr;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            arm_cnt_q <= arm_cnt_d;
            ts_q      <= ts_d;
            q_q       <= q_d;
            q_err_q   <= q_err_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            state_q   <= state_d;
        end
    end

    // FIFO storage: {mode, ts} captured in the violation cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {mode, ts_q};
        end
    end

    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign ev_valid = (state_q == SHOW);
    assign ev_mode  = (state_q == SHOW) ? head[TS_W] : 1'b0;
    assign ev_ts    = (state_q == SHOW) ? head[TS_W-1:0] : '0;

    assign q        = q_q;
    assign q_err    = q_err_q;
    assign viol_cnt = cnt_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_setuphold_viol_monitor.sv
// Scoreboard bench for setuphold_viol_monitor: stimulus pushes expected
// {mode, ts} events, a negedge monitor pops and compares on each handshake.
// A second instance with CNT_W=2 covers counter saturation.
// Expected q in the coincident-capture case follows VIOL_HOLD_LAST_EN.
module tb_setuphold_viol_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode, data, ntfr, clr, ev_ready;
    logic        q, q_err, ovf, ev_valid, ev_mode;
    logic [7:0]  viol_cnt;
    logic [15:0] ev_ts;

    logic        s_q, s_q_err, s_ovf, s_ev_valid, s_ev_mode;
    logic [1:0]  s_viol_cnt;
    logic [15:0] s_ev_ts;

    int          vectors = 0;
    int          miscompares = 0;
    int          edges = 0;
    logic [16:0] exp_q[$];

    always #5 clk = ~clk;

    setuphold_viol_monitor #(.DEPTH(4), .CNT_W(8), .TS_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .data(data), .ntfr(ntfr),
        .clr(clr), .q(q), .q_err(q_err), .viol_cnt(viol_cnt), .ovf(ovf),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_mode(ev_mode), .ev_ts(ev_ts)
    );

    setuphold_viol_monitor #(.DEPTH(4), .CNT_W(2), .TS_W(16)) u_small (
        .clk(clk), .rst_n(rst_n), .mode(mode), .data(data), .ntfr(ntfr),
        .clr(clr), .q(s_q), .q_err(s_q_err), .viol_cnt(s_viol_cnt), .ovf(s_ovf),
        .ev_valid(s_ev_valid), .ev_ready(ev_ready), .ev_mode(s_ev_mode), .ev_ts(s_ev_ts)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst_n) edges++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // toggle the notifier; the violation pulse lands two edges later, at ts = edges+2
    task automatic toggle(input logic m, input logic expect_ev);
        ntfr = ~ntfr;
        if (expect_ev) exp_q.push_back({m, 16'(edges + 2)});
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // scoreboard monitor: compare the head on every accepted event
    always @(negedge clk) begin
        if (rst_n && ev_valid && ev_ready) begin
            if (exp_q.size() == 0) begin
                chk("ev_unexpected", 32'({ev_mode, ev_ts}), 32'h1ffff);
            end else begin
                chk("ev_head", 32'({ev_mode, ev_ts}), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; mode = 1'b0; data = 1'b0; ntfr = 1'b1; clr = 1'b0; ev_ready = 1'b0;
        ticks(3);
        chk("rst_viol_cnt", 32'(viol_cnt), 0);
        chk("rst_ev_valid", 32'(ev_valid), 0);
        chk("rst_q",        32'(q), 0);

        // T1: notifier high across reset release gives no event
        rst_n = 1'b1; edges = 0;
        ticks(10);
        chk("t1_ev_valid", 32'(ev_valid), 0);
        chk("t1_viol_cnt", 32'(viol_cnt), 0);
        chk("t1_q_err",    32'(q_err), 0);
        chk("t1_ovf",      32'(ovf), 0);

        // T2: single violation with mode=1
        mode = 1'b1;
        toggle(1'b1, 1'b1);
        ticks(2);
        chk("t2_cnt_early",   32'(viol_cnt), 0);
        chk("t2_valid_early", 32'(ev_valid), 0);
        tick();
        chk("t2_viol_cnt", 32'(viol_cnt), 1);
        chk("t2_q_err",    32'(q_err), 1);
        chk("t2_ev_valid", 32'(ev_valid), 1);
        chk("t2_ev_mode",  32'(ev_mode), 1);
        chk("t2_ev_ts",    32'(ev_ts), 12);
        ev_ready = 1'b1; tick(); ev_ready = 1'b0;
        chk("t2_ev_valid_after_pop", 32'(ev_valid), 0);
        chk("t2_ev_ts_empty",        32'(ev_ts), 0);
        clr_pulse();
        chk("t2_clr_cnt",   32'(viol_cnt), 0);
        chk("t2_clr_q_err", 32'(q_err), 0);

        // T3: overflow with mode=0, six toggles into a 4-entry FIFO
        mode = 1'b0;
        for (int i = 0; i < 6; i++) begin
            toggle(1'b0, (i < 4) ? 1'b1 : 1'b0);
            ticks(4);
        end
        chk("t3_viol_cnt", 32'(viol_cnt), 6);
        chk("t3_ovf",      32'(ovf), 1);
        chk("t3_q_err",    32'(q_err), 0);
        chk("t3_ev_valid", 32'(ev_valid), 1);
        ev_ready = 1'b1; ticks(4); ev_ready = 1'b0;
        chk("t3_drained", 32'(ev_valid), 0);
        clr_pulse();
        chk("t3_clr_ovf", 32'(ovf), 0);
        chk("t3_clr_cnt", 32'(viol_cnt), 0);

        // T4: full FIFO popped in the violation cycle, nothing dropped
        mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            toggle(1'b1, 1'b1);
            ticks(4);
        end
        chk("t4_full_valid", 32'(ev_valid), 1);
        toggle(1'b1, 1'b1);
        ticks(2);
        ev_ready = 1'b1; tick(); ev_ready = 1'b0;
        chk("t4_ovf",      32'(ovf), 0);
        chk("t4_viol_cnt", 32'(viol_cnt), 5);
        chk("t4_ev_valid", 32'(ev_valid), 1);
        ev_ready = 1'b1; ticks(4); ev_ready = 1'b0;
        chk("t4_drained",  32'(ev_valid), 0);
        chk("t4_sb_empty", 32'(exp_q.size()), 0);
        clr_pulse();

        // T5: saturation on the 2-bit counter, then clr coincident with a violation
        mode = 1'b0; ev_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            toggle(1'b0, 1'b1);
            ticks(4);
        end
        chk("t5_small_sat", 32'(s_viol_cnt), 3);
        chk("t5_main_cnt",  32'(viol_cnt), 5);
        mode = 1'b1;
        toggle(1'b1, 1'b1);
        ticks(2);
        clr_pulse();
        chk("t5_small_clr_cnt", 32'(s_viol_cnt), 1);
        chk("t5_main_clr_cnt",  32'(viol_cnt), 1);
        chk("t5_clr_q_err",     32'(q_err), 1);
        chk("t5_clr_ovf",       32'(ovf), 0);
        ticks(2);

        // T6: violation pulse coincident with a mode=1 capture edge
        mode = 1'b1; data = 1'b0;
        tick();
        chk("t6_q_pre", 32'(q), 0);
        toggle(1'b1, 1'b1);
        ticks(2);
        data = 1'b1;
        tick();
`ifdef VIOL_HOLD_LAST_EN
        chk("t6_q_coincident", 32'(q), 0);
`else
        chk("t6_q_coincident", 32'(q), 1);
`endif
        tick();
        chk("t6_q_next", 32'(q), 1);
        ticks(2);
        chk("t6_sb_empty", 32'(exp_q.size()), 0);

        // reset mid-burst: pending events and synchroniser state are discarded
        ev_ready = 1'b0; mode = 1'b0;
        toggle(1'b0, 1'b0); ticks(4);
        toggle(1'b0, 1'b0); ticks(4);
        toggle(1'b0, 1'b0); tick();
        chk("rst2_pre_valid", 32'(ev_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2_q",        32'(q), 0);
        chk("rst2_q_err",    32'(q_err), 0);
        chk("rst2_viol_cnt", 32'(viol_cnt), 0);
        chk("rst2_ovf",      32'(ovf), 0);
        chk("rst2_ev_valid", 32'(ev_valid), 0);
        chk("rst2_ev_mode",  32'(ev_mode), 0);
        chk("rst2_ev_ts",    32'(ev_ts), 0);
        ticks(2);
        rst_n = 1'b1; edges = 0;
        ticks(10);
        chk("rst2_post_valid", 32'(ev_valid), 0);
        chk("rst2_post_cnt",   32'(viol_cnt), 0);
        chk("final_sb_empty",  32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
